rx_fsrc: RTL and testbench

//  Receive-side counterpart of the TX fractional sample rate converter: drops the hole

---
 rtl/rx_fsrc_pkg.sv | 35 +++
 rtl/rx_fsrc_lane_pack.sv | 48 ++++
 rtl/rx_fsrc.sv | 147 ++++++++++++++
 tb/tb_rx_fsrc.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_fsrc_pkg.sv
// Shared geometry, sample type and hole-classification helpers for rx_fsrc.
// Geometry: 256-bit beats, 16-bit samples, 8 converter lanes, so N = 2 samples per lane.
package rx_fsrc_pkg;

  localparam int DATA_WIDTH = 256;
  localparam int NP         = 16;
  localparam int MAX_CONV   = 8;
  localparam int N          = DATA_WIDTH / NP / MAX_CONV;
  localparam int FILL_W     = $clog2(2 * N);
  localparam int CONV_W     = $clog2(MAX_CONV);
  localparam int LANE_W     = N * NP;

  typedef logic [NP-1:0] sample_t;

  // Bit j is set when sample j of the reference lane equals the hole pattern (exact NP-bit match).
  function automatic logic [N-1:0] hole_mask(input logic [LANE_W-1:0] lane, input sample_t pattern);
    logic [N-1:0] m;
    m = '0;
    for (int j = 0; j < N; j++) begin
      m[j] = (lane[j*NP +: NP] == pattern);
    end
    return m;
  endfunction

  // Index of the lowest enabled converter; an empty mask falls back to converter 0.
  function automatic logic [CONV_W-1:0] lowest_set(input logic [MAX_CONV-1:0] mask);
    logic [CONV_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CONV - 1; i >= 0; i--) begin
      if (mask[i]) idx = CONV_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rx_fsrc_lane_pack.sv
// Per-converter compaction buffer. Appends the non-hole samples of the incoming
// lane at the current fill position and, on emit, shifts the first N samples out.
// Only the residue (< N samples) is held between beats.
module rx_fsrc_lane_pack
  import rx_fsrc_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              emit,
  input  logic [FILL_W-1:0] fill,
  input  logic [N-1:0]      hole,
  input  logic [LANE_W-1:0] lane_in,
  output logic [LANE_W-1:0] pack_word
);

  logic [N-1:0][NP-1:0]   buf_q;
  logic [2*N-1:0][NP-1:0] work;
  logic [FILL_W-1:0]      cnt;

  // Merge held residue with the retained samples of this beat, oldest first.
  always_comb begin
    work = '0;
    cnt  = fill;
    for (int i = 0; i < N; i++) begin
      work[i] = buf_q[i];
    end
    for (int j = 0; j < N; j++) begin
      if (!hole[j]) begin
        work[cnt] = lane_in[j*NP +: NP];
        cnt       = cnt + 1'b1;
      end
    end
    pack_word = work[N-1:0];
  end

  // Keep the merged samples; after an emit only the part beyond the first N is kept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_q <= '0;
    end else if (load) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= emit ? work[i+N] : work[i];
      end
    end
  end

endmodule

// File: rtl/rx_fsrc.sv
// RX fractional sample rate converter: drops hole samples inserted by the far-end
// TX FSRC and repacks the remaining samples into full beats.
// Holes are classified on the reference converter (lowest bit of conv_mask) and
// dropped at the same positions on every converter.
// Optional macro FSRC_RX_STATS_EN adds saturating hole_count / beat_count outputs.
// Handshake: a beat moves on in_valid&&in_ready (resp. out_valid&&out_ready);
// out_valid/out_data hold until taken, in_ready never looks at in_valid.
module rx_fsrc
  import rx_fsrc_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  fsrc_en,
  input  logic                  flush,
  input  logic [MAX_CONV-1:0]   conv_mask,
  input  sample_t               hole_pattern,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [FILL_W-1:0]     fill_level
`ifdef FSRC_RX_STATS_EN
  ,
  output logic [31:0]           hole_count,
  output logic [31:0]           beat_count
`endif
);

  logic                  accept;
  logic                  load;
  logic                  emit;
  logic                  fsrc_en_q;
  logic                  en_chg;
  logic [FILL_W-1:0]     fill_q;
  logic [FILL_W-1:0]     fill_eff;
  logic [FILL_W-1:0]     fill_sum;
  logic [FILL_W-1:0]     keep_cnt;
  logic [CONV_W-1:0]     ref_idx;
  logic [N-1:0]          hole;
  logic [LANE_W-1:0]     lane_in  [MAX_CONV];
  logic [LANE_W-1:0]     lane_out [MAX_CONV];
  logic [DATA_WIDTH-1:0] next_beat;

  assign in_ready = resetn && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign load     = accept && fsrc_en;

  // A mode change discards the residue; a beat accepted in that cycle starts from empty.
  assign en_chg   = (fsrc_en != fsrc_en_q);
  assign fill_eff = en_chg ? '0 : fill_q;

  assign ref_idx  = lowest_set(conv_mask);
  assign hole     = hole_mask(lane_in[ref_idx], hole_pattern);
  assign fill_sum = fill_eff + keep_cnt;
  assign emit     = (fill_sum >= FILL_W'(N));

  // Count retained (non-hole) positions in the beat.
  always_comb begin
    keep_cnt = '0;
    for (int j = 0; j < N; j++) begin
      if (!hole[j]) keep_cnt = keep_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < MAX_CONV; c++) begin : g_lane
    assign lane_in[c] = in_data[c*LANE_W +: LANE_W];

    rx_fsrc_lane_pack u_pack (
      .clk       (clk),
      .resetn    (resetn),
      .load      (load),
      .emit      (emit),
      .fill      (fill_eff),
      .hole      (hole),
      .lane_in   (lane_in[c]),
      .pack_word (lane_out[c])
    );
  end

  // Select compacted or bypass data per lane and zero disabled converters.
  always_comb begin
    next_beat = '0;
    for (int c = 0; c < MAX_CONV; c++) begin
      if (conv_mask[c]) begin
        next_beat[c*LANE_W +: LANE_W] = fsrc_en ? lane_out[c] : lane_in[c];
      end
    end
  end

  // Track the previous mode to detect fsrc_en changes.
  always_ff @(posedge clk) begin
    fsrc_en_q <= fsrc_en;
  end

  // Fill level: cleared by reset, flush, bypass or mode change; advanced by accepted beats.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fill_q <= '0;
    end else if (flush || !fsrc_en) begin
      fill_q <= '0;
    end else if (accept) begin
      fill_q <= emit ? (fill_sum - FILL_W'(N)) : fill_sum;
    end else begin
      fill_q <= fill_eff;
    end
  end

  // Output register: load a full beat, otherwise drop valid once the beat is taken.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept && (!fsrc_en || emit)) begin
      out_valid <= 1'b1;
      out_data  <= next_beat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign fill_level = fill_q;

`ifdef FSRC_RX_STATS_EN
  localparam logic [31:0] CNT_MAX = '1;
  logic [31:0] beat_holes;

  assign beat_holes = 32'(N) - 32'(keep_cnt);

  // Saturating statistics, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hole_count <= '0;
      beat_count <= '0;
    end else begin
      if (load) begin
        hole_count <= (hole_count > CNT_MAX - beat_holes) ? CNT_MAX : hole_count + beat_holes;
      end
      if (out_valid && out_ready && beat_count != CNT_MAX) begin
        beat_count <= beat_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_fsrc.sv
// Self-checking bench for rx_fsrc: directed cases plus a random stream compared
// against a column-queue reference model through an expected-beat scoreboard.
module tb_rx_fsrc;

  localparam int NS = 2;   // samples per lane
  localparam int NC = 8;   // converter lanes

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         fsrc_en = 1'b0;
  logic         flush = 1'b0;
  logic [7:0]   conv_mask = 8'hFF;
  logic [15:0]  hole_pattern = 16'h8000;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_data = '0;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic [1:0]   fill_level;
`ifdef FSRC_RX_STATS_EN
  logic [31:0]  hole_count;
  logic [31:0]  beat_count;
`endif

  int           n_checks = 0;
  int           n_errors = 0;
  logic [255:0] exp_q[$];
  logic [127:0] col_q[$];
  logic         rand_ready = 1'b0;
  logic         ready_force = 1'b1;
  logic [31:0]  last_lane0 = '0;
  int           n_out = 0;

  rx_fsrc dut (
    .clk          (clk),
    .resetn       (resetn),
    .fsrc_en      (fsrc_en),
    .flush        (flush),
    .conv_mask    (conv_mask),
    .hole_pattern (hole_pattern),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .fill_level   (fill_level)
`ifdef FSRC_RX_STATS_EN
    ,
    .hole_count   (hole_count),
    .beat_count   (beat_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // downstream ready: forced level or random
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mask_beat(input logic [255:0] d, input logic [7:0] m);
    for (int c = 0; c < NC; c++) begin
      if (!m[c]) d[c*32 +: 32] = '0;
    end
    return d;
  endfunction

  function automatic int ref_of(input logic [7:0] m);
    int r;
    r = 0;
    for (int c = NC - 1; c >= 0; c--) begin
      if (m[c]) r = c;
    end
    return r;
  endfunction

  function automatic logic [255:0] rnd_beat();
    logic [255:0] d;
    for (int i = 0; i < NC * NS; i++) begin
      d[i*16 +: 16] = 16'($urandom_range(0, 16'h7FFF));
    end
    return d;
  endfunction

  function automatic logic [255:0] set_lane(input logic [255:0] d, input int lane,
                                            input logic [15:0] s0, input logic [15:0] s1);
    d[lane*32 +: 16]      = s0;
    d[lane*32 + 16 +: 16] = s1;
    return d;
  endfunction

  // reference model: one column (all lanes at a sample position) per retained position
  task automatic model_accept(input logic [255:0] d);
    int           r;
    logic [127:0] col;
    logic [255:0] e;
    if (!fsrc_en) begin
      exp_q.push_back(mask_beat(d, conv_mask));
    end else begin
      r = ref_of(conv_mask);
      for (int j = 0; j < NS; j++) begin
        if (d[(r*NS + j)*16 +: 16] != hole_pattern) begin
          col = '0;
          for (int c = 0; c < NC; c++) col[c*16 +: 16] = d[(c*NS + j)*16 +: 16];
          col_q.push_back(col);
        end
      end
      if (col_q.size() >= NS) begin
        e = '0;
        for (int j = 0; j < NS; j++) begin
          col = col_q.pop_front();
          for (int c = 0; c < NC; c++) e[(c*NS + j)*16 +: 16] = col[c*16 +: 16];
        end
        exp_q.push_back(mask_beat(e, conv_mask));
      end
    end
  endtask

  // driver: hold the beat until accepted; returns 1 time unit after the accepting edge
  task automatic send_beat(input logic [255:0] d);
    in_data  = d;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic set_en(input logic v);
    if (v != fsrc_en) col_q.delete();
    fsrc_en = v;
  endtask

  // flush with a simultaneous input offer that must be refused
  task automatic do_flush(input logic [255:0] d);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    col_q.delete();
    check("flush_fill", fill_level, 2'd0);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 2000; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  // scoreboard: every valid output must match the oldest expected beat
  always @(negedge clk) begin
    if (resetn && out_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", out_valid, 1'b0);
      end else begin
        check("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
      if (out_ready) begin
        last_lane0 = out_data[31:0];
        n_out++;
      end else begin
        check("stall_in_ready", in_ready, 1'b0);
      end
    end
  end

  initial begin
    logic [255:0] d;
    int           n0;
    int           r;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_fill", fill_level, 2'd0);
    check("rst_in_ready", in_ready, 1'b0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // bypass: beat reappears one cycle later
    d = set_lane(rnd_beat(), 0, 16'h0001, 16'h0002);
    send_beat(d);
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_lane0", out_data[31:0], 32'h0002_0001);
    check("t1_fill", fill_level, 2'd0);
    wait_drain();

    // compaction sequence on lane 0
    set_en(1'b1);
    @(posedge clk);
    #1;
    n0 = n_out;
    send_beat(set_lane(rnd_beat(), 0, 16'h8000, 16'h000A));
    check("t2_fill1", fill_level, 2'd1);
    send_beat(set_lane(rnd_beat(), 0, 16'h000B, 16'h000C));
    check("t2_fill2", fill_level, 2'd1);
    check("t2_emit_ab", out_data[31:0], 32'h000B_000A);
    send_beat(set_lane(rnd_beat(), 0, 16'h8000, 16'h8000));
    check("t2_allhole_fill", fill_level, 2'd1);
    check("t2_allhole_noout", out_valid, 1'b0);
    send_beat(set_lane(rnd_beat(), 0, 16'h000D, 16'h8000));
    check("t2_fill4", fill_level, 2'd0);
    wait_drain();
    check("t2_out_count", n_out - n0, 2);
    check("t2_last", last_lane0, 32'h000D_000C);

    // reference converter follows conv_mask
    conv_mask = 8'h0C;
    d = set_lane(rnd_beat(), 2, 16'h8000, 16'h0001);
    d = set_lane(d, 0, 16'h8000, 16'h0005);
    send_beat(d);
    check("t4_fill", fill_level, 2'd1);
    send_beat(set_lane(rnd_beat(), 2, 16'h0002, 16'h0003));
    check("t4_lane01_zero", out_data[63:0], 64'h0);
    check("t4_lane2", out_data[95:64], 32'h0002_0001);
    check("t4_lane47_zero", out_data[255:128], 128'h0);
    wait_drain();
    conv_mask = 8'hFF;
    do_flush(rnd_beat());

    // flush discards the held sample
    send_beat(set_lane(rnd_beat(), 0, 16'h8000, 16'h000A));
    check("t5_fill", fill_level, 2'd1);
    do_flush(rnd_beat());
    send_beat(set_lane(rnd_beat(), 0, 16'h000B, 16'h000C));
    check("t5_out", out_data[31:0], 32'h000C_000B);
    check("t5_fill_end", fill_level, 2'd0);
    wait_drain();

    // backpressure hold
    ready_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_beat(set_lane(rnd_beat(), 0, 16'h0011, 16'h0022));
    repeat (4) @(posedge clk);
    #1;
    check("t3_hold_valid", out_valid, 1'b1);
    check("t3_hold_in_ready", in_ready, 1'b0);
    check("t3_hold_lane0", out_data[31:0], 32'h0022_0011);
    ready_force = 1'b1;
    wait_drain();

    // random stream with random ready, mode and mask changes
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i % 100 == 50) begin
        set_en($urandom_range(0, 3) != 0);
        conv_mask = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      end
      d = rnd_beat();
      r = ref_of(conv_mask);
      for (int j = 0; j < NS; j++) begin
        if ($urandom_range(0, 2) == 0) d[(r*NS + j)*16 +: 16] = 16'h8000;
      end
      send_beat(d);
    end
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    repeat (2) @(posedge clk);
    wait_drain();

    // reset in the middle of a stream
    set_en(1'b1);
    conv_mask   = 8'hFF;
    ready_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_flush(rnd_beat());
    send_beat(set_lane(rnd_beat(), 0, 16'h8000, 16'h000A));
    send_beat(set_lane(rnd_beat(), 0, 16'h000B, 16'h000C));
    check("t6_pre_valid", out_valid, 1'b1);
    check("t6_pre_fill", fill_level, 2'd1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_in_ready", in_ready, 1'b0);
    check("t6_fill", fill_level, 2'd0);
`ifdef FSRC_RX_STATS_EN
    check("t6_hole_count", hole_count, 32'd0);
    check("t6_beat_count", beat_count, 32'd0);
`endif
    exp_q.delete();
    col_q.delete();
    resetn      = 1'b1;
    ready_force = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_partial", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
